// File: rtl/lab2_proc_imul_arbiter_if.sv
// Val/rdy bundle joining the requesters, the round-robin arbiter and the shared multiplier.
// master = requesters plus multiplier side of the world, slave = the arbiter itself.
interface lab2_proc_imul_arbiter_if #(
  parameter int p_nreqs = 2
);
  logic [p_nreqs-1:0]    req_val;
  logic [p_nreqs-1:0]    req_rdy;
  logic [64*p_nreqs-1:0] req_msg;
  logic [p_nreqs-1:0]    resp_val;
  logic [p_nreqs-1:0]    resp_rdy;
  logic [31:0]           resp_msg;
  logic                  imul_req_val;
  logic                  imul_req_rdy;
  logic [63:0]           imul_req_msg;
  logic                  imul_resp_val;
  logic                  imul_resp_rdy;
  logic [31:0]           imul_resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy, imul_req_rdy, imul_resp_val, imul_resp_msg,
    input  req_rdy, resp_val, resp_msg, imul_req_val, imul_req_msg, imul_resp_rdy
  );

  modport slave (
    input  req_val, req_msg, resp_rdy, imul_req_rdy, imul_resp_val, imul_resp_msg,
    output req_rdy, resp_val, resp_msg, imul_req_val, imul_req_msg, imul_resp_rdy
  );
endinterface

// File: rtl/lab2_proc_imul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among p_nreqs requesters, one op in flight.
// Optional per-requester grant counters are enabled with LAB2_PROC_IMUL_ARBITER_STATS_EN.
module lab2_proc_imul_arbiter #(
  parameter  int p_nreqs = 2,
  localparam int c_pw    = (p_nreqs > 1) ? $clog2(p_nreqs) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  lab2_proc_imul_arbiter_if.slave      bus,
  output logic                         o_busy,
  output logic [c_pw-1:0]              o_owner
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  ,
  output logic [32*p_nreqs-1:0]        o_grant_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_pw-1:0]    r_ptr;
  logic [c_pw-1:0]    r_owner;
  logic [c_pw-1:0]    w_grant;
  logic [c_pw-1:0]    w_ptr_next;
  logic               w_found;
  logic               w_req_fire;
  logic               w_resp_fire;
  logic [p_nreqs-1:0] w_req_rdy;
  logic [p_nreqs-1:0] w_resp_val;
  logic [31:0]        w_resp_msg;
  logic               w_imul_req_val;
  logic               w_imul_resp_rdy;
  logic [63:0]        w_imul_req_msg;

  // Zero-cycle grant: first valid requester at or after the priority pointer, wrapping.
  always_comb begin
    int v_idx;
    w_grant = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int k = 0; k < p_nreqs; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= p_nreqs) begin
        v_idx = v_idx - p_nreqs;
      end
      if (!w_found && bus.req_val[v_idx]) begin
        w_found = 1'b1;
        w_grant = c_pw'(v_idx);
      end
    end
    if (reset) begin
      w_grant = '0;
    end
  end

  assign w_ptr_next = (w_grant == c_pw'(p_nreqs - 1)) ? '0 : w_grant + 1'b1;

  // Outputs stay quiet throughout reset so nothing leaks from a pre-reset state.
  always_comb begin
    w_state_next    = r_state;
    w_req_rdy       = '0;
    w_resp_val      = '0;
    w_resp_msg      = '0;
    w_imul_req_val  = 1'b0;
    w_imul_resp_rdy = 1'b0;
    w_req_fire      = 1'b0;
    w_resp_fire     = 1'b0;
    w_imul_req_msg  = bus.req_msg[64*int'(w_grant) +: 64];
    if (!reset) begin
      case (r_state)
        IDLE: begin
          w_imul_req_val     = |bus.req_val;
          w_req_rdy[w_grant] = w_imul_req_val & bus.imul_req_rdy;
          w_req_fire         = w_imul_req_val & bus.imul_req_rdy;
          if (w_req_fire) begin
            w_state_next = BUSY;
          end
        end
        BUSY: begin
          w_resp_val[r_owner] = bus.imul_resp_val;
          w_resp_msg          = bus.imul_resp_msg;
          w_imul_resp_rdy     = bus.resp_rdy[r_owner];
          w_resp_fire         = bus.imul_resp_val & bus.resp_rdy[r_owner];
          if (w_resp_fire) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) begin
        r_owner <= w_grant;
        r_ptr   <= w_ptr_next;
      end else if (w_resp_fire) begin
        r_owner <= '0;
      end
    end
  end

  assign bus.req_rdy       = w_req_rdy;
  assign bus.resp_val      = w_resp_val;
  assign bus.resp_msg      = w_resp_msg;
  assign bus.imul_req_val  = w_imul_req_val;
  assign bus.imul_req_msg  = w_imul_req_msg;
  assign bus.imul_resp_rdy = w_imul_resp_rdy;
  assign o_busy            = (r_state == BUSY) && !reset;
  assign o_owner           = reset ? '0 : r_owner;

`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  // One free-running 32b counter per requester, bumped on every request fire it wins.
  logic [31:0] r_grant_cnt [p_nreqs];

  for (genvar gi = 0; gi < p_nreqs; gi++) begin : g_stats
    always_ff @(posedge clk) begin
      if (reset) begin
        r_grant_cnt[gi] <= '0;
      end else if (w_req_fire && (w_grant == c_pw'(gi))) begin
        r_grant_cnt[gi] <= r_grant_cnt[gi] + 32'd1;
      end
    end
    assign o_grant_cnt[32*gi +: 32] = r_grant_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_lab2_proc_imul_arbiter.sv
// Self-checking bench: randomized requesters and multiplier model, round-robin reference model
// and per-requester product scoreboard, plus directed reset/grant/backpressure scenarios.
module tb_lab2_proc_imul_arbiter;
  localparam int NREQ = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [0:0] owner;
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
  logic [32*NREQ-1:0] grantCnt;
`endif

  always #5 clk = ~clk;

  lab2_proc_imul_arbiter_if #(.p_nreqs(NREQ)) bus ();

  lab2_proc_imul_arbiter #(.p_nreqs(NREQ)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_busy  (busy),
    .o_owner (owner)
`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
    ,
    .o_grant_cnt (grantCnt)
`endif
  );

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] expQ [NREQ][$];
  int          grantLog [$];
  int          grantsSeen [NREQ];

  logic [NREQ-1:0] sReqRdy;
  logic            sImulReqVal;
  logic            sImulRespRdy;
  logic [63:0]     sImulReqMsg;

  logic rdyRand = 1'b0;
  int   mulLat  = 4;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Requester issue: drive val/msg and record the product it must eventually receive.
  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] prod;
    prod = a * b;
    bus.req_msg[64*idx +: 64] = {a, b};
    bus.req_val[idx] = 1'b1;
    expQ[idx].push_back(prod);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_val[i] && sReqRdy[i]) begin
        bus.req_val[i] = 1'b0;
        grantLog.push_back(i);
      end
    end
    #1;
  endtask

  function automatic bit allDone();
    bit done;
    done = (bus.req_val == '0);
    for (int i = 0; i < NREQ; i++) begin
      if (expQ[i].size() != 0) done = 1'b0;
    end
    return done;
  endfunction

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!allDone() && n < budget) begin
      nextCycle();
      n++;
    end
    if (!allDone()) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout: outstanding work after %0d cycles, expected none", budget);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      sReqRdy      = bus.req_rdy;
      sImulReqVal  = bus.imul_req_val;
      sImulRespRdy = bus.imul_resp_rdy;
      sImulReqMsg  = bus.imul_req_msg;
    end
  end

  // Multiplier model: one op at a time, programmable latency, response held until taken.
  initial begin
    bit          mulBusy;
    int          mulCnt;
    logic [31:0] mulProd;
    mulBusy = 1'b0;
    mulCnt  = 0;
    mulProd = '0;
    bus.imul_req_rdy  = 1'b0;
    bus.imul_resp_val = 1'b0;
    bus.imul_resp_msg = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mulBusy = 1'b0;
        bus.imul_resp_val = 1'b0;
      end else if (!mulBusy) begin
        if (sImulReqVal && bus.imul_req_rdy) begin
          mulBusy = 1'b1;
          mulProd = sImulReqMsg[63:32] * sImulReqMsg[31:0];
          mulCnt  = mulLat;
        end
      end else if (bus.imul_resp_val && sImulRespRdy) begin
        mulBusy = 1'b0;
        bus.imul_resp_val = 1'b0;
      end
      if (mulBusy && !bus.imul_resp_val) begin
        mulCnt--;
        if (mulCnt <= 0) begin
          bus.imul_resp_val = 1'b1;
          bus.imul_resp_msg = mulProd;
        end
      end
      if (!mulBusy) bus.imul_resp_msg = $urandom;
      bus.imul_req_rdy = !mulBusy && (!rdyRand || ($urandom_range(0, 3) != 0));
    end
  end

  // Reference model and scoreboard monitor: round-robin from a pointer, one op in flight.
  initial begin
    bit mBusy;
    int mPtr;
    int mOwner;
    int g;
    int idx;
    mBusy  = 1'b0;
    mPtr   = 0;
    mOwner = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("rst_req_rdy", 64'(bus.req_rdy), 0);
        checkOutput("rst_resp_val", 64'(bus.resp_val), 0);
        checkOutput("rst_imul_req_val", 64'(bus.imul_req_val), 0);
        checkOutput("rst_imul_resp_rdy", 64'(bus.imul_resp_rdy), 0);
        checkOutput("rst_busy", 64'(busy), 0);
        checkOutput("rst_owner", 64'(owner), 0);
        if (mBusy && expQ[mOwner].size() != 0) void'(expQ[mOwner].pop_front());
        mBusy  = 1'b0;
        mPtr   = 0;
        mOwner = 0;
        for (int i = 0; i < NREQ; i++) grantsSeen[i] = 0;
      end else if (!mBusy) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (mPtr + k) % NREQ;
          if (g < 0 && bus.req_val[idx]) g = idx;
        end
        checkOutput("idle_busy", 64'(busy), 0);
        checkOutput("idle_owner", 64'(owner), 0);
        checkOutput("idle_resp_val", 64'(bus.resp_val), 0);
        checkOutput("idle_imul_resp_rdy", 64'(bus.imul_resp_rdy), 0);
        checkOutput("idle_imul_req_val", 64'(bus.imul_req_val), (g >= 0) ? 64'd1 : 64'd0);
        if (g >= 0) begin
          checkOutput("grant_req_rdy", 64'(bus.req_rdy), bus.imul_req_rdy ? (64'd1 << g) : 64'd0);
          checkOutput("grant_msg", bus.imul_req_msg, bus.req_msg[64*g +: 64]);
          if (bus.imul_req_rdy) begin
            mBusy  = 1'b1;
            mOwner = g;
            mPtr   = (g + 1) % NREQ;
            grantsSeen[g]++;
          end
        end else begin
          checkOutput("idle_req_rdy", 64'(bus.req_rdy), 0);
        end
      end else begin
        checkOutput("busy_flag", 64'(busy), 1);
        checkOutput("busy_owner", 64'(owner), 64'(mOwner));
        checkOutput("busy_req_rdy", 64'(bus.req_rdy), 0);
        checkOutput("busy_imul_req_val", 64'(bus.imul_req_val), 0);
        checkOutput("busy_resp_val", 64'(bus.resp_val), bus.imul_resp_val ? (64'd1 << mOwner) : 64'd0);
        checkOutput("busy_imul_resp_rdy", 64'(bus.imul_resp_rdy), 64'(bus.resp_rdy[mOwner]));
        if (bus.imul_resp_val && bus.resp_rdy[mOwner]) begin
          if (expQ[mOwner].size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL sb_unexpected: response to requester %0d, expected none pending", mOwner);
          end else begin
            checkOutput("sb_product", 64'(bus.resp_msg), 64'(expQ[mOwner].pop_front()));
          end
          mBusy  = 1'b0;
          mOwner = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int left [NREQ];
    int expGrants [4];
    expGrants[0] = 0; expGrants[1] = 1; expGrants[2] = 0; expGrants[3] = 1;

    reset        = 1'b1;
    bus.req_val  = '0;
    bus.req_msg  = '0;
    bus.resp_rdy = '1;

    // Reset held with both requesters asking: nothing may be granted.
    applyStimulus(0, 32'd3, 32'd5);
    applyStimulus(1, 32'd9, 32'd11);
    nextCycle();
    nextCycle();
    checkOutput("t1_req_rdy", 64'(bus.req_rdy), 0);
    checkOutput("t1_imul_req_val", 64'(bus.imul_req_val), 0);
    checkOutput("t1_busy", 64'(busy), 0);
    checkOutput("t1_owner", 64'(owner), 0);
    reset = 1'b0;
    #1;
    checkOutput("t1_first_grant", 64'(bus.req_rdy), 64'd1);
    checkOutput("t1_first_msg", bus.imul_req_msg, {32'd3, 32'd5});
    waitIdle(100);

    // Single request from requester 1.
    applyStimulus(1, 32'd7, 32'd6);
    #1;
    checkOutput("t2_imul_req_msg", bus.imul_req_msg, {32'd7, 32'd6});
    checkOutput("t2_req_rdy", 64'(bus.req_rdy), 64'b10);
    nextCycle();
    checkOutput("t2_busy", 64'(busy), 1);
    checkOutput("t2_owner", 64'(owner), 1);
    n = 0;
    while (bus.resp_val == '0 && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("t2_resp_val", 64'(bus.resp_val), 64'b10);
    checkOutput("t2_resp_msg", 64'(bus.resp_msg), 64'd42);
    waitIdle(100);

    // Round-robin with both requesters continuously valid.
    grantLog.delete();
    applyStimulus(0, $urandom, $urandom);
    applyStimulus(1, $urandom, $urandom);
    left[0] = 1;
    left[1] = 1;
    n = 0;
    while (grantLog.size() < 4 && n < 200) begin
      nextCycle();
      n++;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_val[i] && left[i] > 0) begin
          applyStimulus(i, $urandom, $urandom);
          left[i]--;
        end
      end
    end
    checkOutput("t3_grant_count", 64'(grantLog.size()), 4);
    for (int k = 0; k < 4 && k < grantLog.size(); k++) begin
      checkOutput($sformatf("t3_grant%0d", k), 64'(grantLog[k]), 64'(expGrants[k]));
    end
    waitIdle(200);

    // Owner backpressure: requester 0 holds the multiplier response off.
    bus.resp_rdy = 2'b10;
    applyStimulus(0, 32'd100, 32'd3);
    n = 0;
    while (bus.resp_val == '0 && n < 20) begin
      nextCycle();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4_resp_val", 64'(bus.resp_val), 64'b01);
      checkOutput("t4_imul_resp_rdy", 64'(bus.imul_resp_rdy), 0);
      checkOutput("t4_busy", 64'(busy), 1);
      nextCycle();
    end
    bus.resp_rdy = 2'b11;
    #1;
    checkOutput("t4_release_rdy", 64'(bus.imul_resp_rdy), 1);
    nextCycle();
    checkOutput("t4_idle_after", 64'(busy), 0);
    waitIdle(50);

    // Reset while requester 1 owns the multiplier.
    bus.resp_rdy = 2'b00;
    applyStimulus(1, 32'd5, 32'd5);
    nextCycle();
    checkOutput("t5_busy", 64'(busy), 1);
    checkOutput("t5_owner", 64'(owner), 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("t5_busy_after", 64'(busy), 0);
    checkOutput("t5_resp_val_after", 64'(bus.resp_val), 0);
    checkOutput("t5_owner_after", 64'(owner), 0);
    applyStimulus(0, 32'd2, 32'd8);
    applyStimulus(1, 32'd4, 32'd4);
    #1;
    checkOutput("t5_ptr_reset", 64'(bus.req_rdy), 64'b01);
    bus.resp_rdy = 2'b11;
    waitIdle(100);

`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, $urandom, $urandom);
      waitIdle(50);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, $urandom, $urandom);
      waitIdle(50);
    end
    checkOutput("t6_cnt0", 64'(grantCnt[31:0]), 64'd5);
    checkOutput("t6_cnt1", 64'(grantCnt[63:32]), 64'd3);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("t6_cnt0_rst", 64'(grantCnt[31:0]), 0);
    checkOutput("t6_cnt1_rst", 64'(grantCnt[63:32]), 0);
`endif

    // Randomized traffic with stalls, backpressure and occasional resets.
    rdyRand = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      nextCycle();
      mulLat       = $urandom_range(1, 5);
      bus.resp_rdy = NREQ'($urandom);
      reset        = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_val[i] && $urandom_range(0, 2) == 0) begin
          applyStimulus(i, $urandom, $urandom);
        end
      end
    end
    reset        = 1'b0;
    rdyRand      = 1'b0;
    bus.resp_rdy = '1;
    waitIdle(300);

`ifdef LAB2_PROC_IMUL_ARBITER_STATS_EN
    checkOutput("stats_rand_cnt0", 64'(grantCnt[31:0]), 64'(grantsSeen[0]));
    checkOutput("stats_rand_cnt1", 64'(grantCnt[63:32]), 64'(grantsSeen[1]));
`endif

    nextCycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
